// File: rtl/vid_timing_pkg.sv
// Shared types and default 640x480 raster timing for the video stream source.
package vid_timing_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam bit SYNC_POL_DEF = 1'b1;

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with active/sync region decode.
module vid_timing_cnt
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clear,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_reg,
  output logic          vs_reg,
  output logic          last_pix
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (run) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  assign h_cnt    = r_h_cnt;
  assign v_cnt    = r_v_cnt;
  assign active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign hs_reg   = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign vs_reg   = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign last_pix = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/vid_stream_gen.sv
// Raster-timed pixel source: pulls 8-bit pixels from a FIFO and emits y/de/hs/vs.
// state | meaning
// IDLE  | counters cleared, no pixels pulled, syncs at inactive level
// RUN   | raster advancing; leaves only at the last pixel of a frame with en low
module vid_stream_gen
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] out_y,
  output logic       out_de,
  output logic       out_hs,
  output logic       out_vs,
  output logic       frame_start,
  output logic       underflow,
  output logic       underflow_err
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_active, w_hs_reg, w_vs_reg, w_last_pix;
  logic          w_run, w_take;
  logic [7:0]    r_y;
  logic          r_de, r_hs, r_vs, r_fs, r_uf, r_uf_err;

  vid_timing_cnt #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .clear    (r_state == IDLE),
    .h_cnt    (w_h_cnt),
    .v_cnt    (w_v_cnt),
    .active   (w_active),
    .hs_reg   (w_hs_reg),
    .vs_reg   (w_vs_reg),
    .last_pix (w_last_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (w_last_pix && !en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_run     = (r_state == RUN);
  assign w_take    = w_run && w_active;
  assign pix_ready = w_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y      <= 8'h00;
      r_de     <= 1'b0;
      r_hs     <= ~SYNC_POL;
      r_vs     <= ~SYNC_POL;
      r_fs     <= 1'b0;
      r_uf     <= 1'b0;
      r_uf_err <= 1'b0;
    end else begin
      r_de <= w_take;
      r_hs <= (w_run && w_hs_reg) ? SYNC_POL : ~SYNC_POL;
      r_vs <= (w_run && w_vs_reg) ? SYNC_POL : ~SYNC_POL;
      r_fs <= w_run && (w_h_cnt == '0) && (w_v_cnt == '0);
      r_uf <= w_take && !pix_valid;
      // Missing data becomes a black pixel; the raster is never stalled.
      if (w_take) r_y <= pix_valid ? pix_data : 8'h00;
      if (w_take && !pix_valid) r_uf_err <= 1'b1;
    end
  end

  assign out_y         = r_y;
  assign out_de        = r_de;
  assign out_hs        = r_hs;
  assign out_vs        = r_vs;
  assign frame_start   = r_fs;
  assign underflow     = r_uf;
  assign underflow_err = r_uf_err;

endmodule

// File: tb/tb_vid_stream_gen.sv
// Directed bench for vid_stream_gen using an 8x6 raster (48 clocks per frame).
module tb_vid_stream_gen;

  localparam bit POL = 1'b1;

  logic       clk = 1'b0;
  logic       rst, en, pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready, out_de, out_hs, out_vs, frame_start, underflow, underflow_err;
  logic [7:0] out_y;

  int checks = 0;
  int failures = 0;
  int idx = 0;
  int drop_idx = -1;

  always #5 clk = ~clk;

  vid_stream_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (POL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .out_y         (out_y),
    .out_de        (out_de),
    .out_hs        (out_hs),
    .out_vs        (out_vs),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_err (underflow_err)
  );

  function automatic bit exp_active(int p);
    return ((p % 8) < 4) && ((p / 8) < 3);
  endfunction

  // Source slot advances on every ready cycle, so a missing pixel never shifts later ones.
  task automatic tick();
    logic took;
    took = pix_ready;
    @(posedge clk);
    #1;
    if (took) idx++;
    pix_data  = 8'(idx + 1);
    pix_valid = (idx != drop_idx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    idx       = 0;
    drop_idx  = -1;
    pix_data  = 8'h01;
    pix_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; pix_valid = 1'b1; pix_data = 8'h55;
    tick();
    tick();
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", out_y); end
    checks++; if (out_de !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", out_de); end
    checks++; if (out_hs !== ~POL) begin failures++; $display("FAIL reset_hs got=%b exp=%b", out_hs, ~POL); end
    checks++; if (out_vs !== ~POL) begin failures++; $display("FAIL reset_vs got=%b exp=%b", out_vs, ~POL); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", pix_ready); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%b exp=0", underflow); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL reset_uf_err got=%b exp=0", underflow_err); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pix_ready !== 1'b0 || out_de !== 1'b0) begin
        failures++; $display("FAIL idle_quiet k=%0d ready=%b de=%b exp=0/0", k, pix_ready, out_de);
      end
    end
  endtask

  task automatic test_stream();
    int p, h, v, rdy_cnt;
    logic [7:0] exp_y;
    logic a;
    do_reset();
    en = 1'b1;
    exp_y = 8'h00;
    rdy_cnt = 0;
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (k <= 48) begin
        p = k - 1;
        rdy_cnt += int'(pix_ready);
        checks++;
        if (pix_ready !== exp_active(p)) begin
          failures++; $display("FAIL stream_ready p=%0d got=%b exp=%b", p, pix_ready, exp_active(p));
        end
      end
      if (k >= 2) begin
        p = k - 2; h = p % 8; v = p / 8;
        a = exp_active(p);
        if (a) exp_y = 8'(v * 4 + h + 1);
        checks++; if (out_de !== a) begin failures++; $display("FAIL stream_de p=%0d got=%b exp=%b", p, out_de, a); end
        checks++; if (out_y !== exp_y) begin failures++; $display("FAIL stream_y p=%0d got=%h exp=%h", p, out_y, exp_y); end
        checks++; if (out_hs !== ((h == 5 || h == 6) ? POL : ~POL)) begin failures++; $display("FAIL stream_hs p=%0d got=%b", p, out_hs); end
        checks++; if (out_vs !== ((v == 4) ? POL : ~POL)) begin failures++; $display("FAIL stream_vs p=%0d got=%b", p, out_vs); end
        checks++; if (frame_start !== (p == 0)) begin failures++; $display("FAIL stream_fs p=%0d got=%b exp=%b", p, frame_start, (p == 0)); end
      end
    end
    checks++; if (rdy_cnt != 12) begin failures++; $display("FAIL stream_ready_count got=%0d exp=12", rdy_cnt); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL stream_uf_err got=%b exp=0", underflow_err); end
  endtask

  task automatic test_underflow();
    int p, n, uf_cnt;
    logic [7:0] exp_y;
    logic a;
    do_reset();
    drop_idx = 2;
    en = 1'b1;
    exp_y = 8'h00;
    uf_cnt = 0;
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (k >= 2) begin
        p = k - 2;
        n = (p / 8) * 4 + (p % 8);
        a = exp_active(p);
        if (a) exp_y = (n == 2) ? 8'h00 : 8'(n + 1);
        uf_cnt += int'(underflow);
        checks++; if (out_y !== exp_y) begin failures++; $display("FAIL uf_y p=%0d got=%h exp=%h", p, out_y, exp_y); end
        checks++; if (underflow !== (a && n == 2)) begin failures++; $display("FAIL uf_pulse p=%0d got=%b exp=%b", p, underflow, (a && n == 2)); end
      end
    end
    checks++; if (uf_cnt != 1) begin failures++; $display("FAIL uf_count got=%0d exp=1", uf_cnt); end
    checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL uf_err got=%b exp=1", underflow_err); end
    for (int k = 0; k < 10; k++) tick();
    checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL uf_err_sticky got=%b exp=1", underflow_err); end
  endtask

  task automatic test_en_drop();
    int de_cnt, fs_cnt, hs_cnt, vs_cnt, rdy_cnt;
    do_reset();
    en = 1'b1;
    de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (k == 10) en = 1'b0;
      if (k >= 2) begin
        de_cnt += int'(out_de);
        fs_cnt += int'(frame_start);
        hs_cnt += int'(out_hs == POL);
        vs_cnt += int'(out_vs == POL);
      end
    end
    checks++; if (de_cnt != 12) begin failures++; $display("FAIL drop_de_count got=%0d exp=12", de_cnt); end
    checks++; if (fs_cnt != 1) begin failures++; $display("FAIL drop_fs_count got=%0d exp=1", fs_cnt); end
    checks++; if (hs_cnt != 12) begin failures++; $display("FAIL drop_hs_count got=%0d exp=12", hs_cnt); end
    checks++; if (vs_cnt != 8) begin failures++; $display("FAIL drop_vs_count got=%0d exp=8", vs_cnt); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL drop_idle_ready got=%b exp=0", pix_ready); end
    de_cnt = 0; fs_cnt = 0; rdy_cnt = 0; hs_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      de_cnt  += int'(out_de);
      fs_cnt  += int'(frame_start);
      rdy_cnt += int'(pix_ready);
      hs_cnt  += int'(out_hs == POL) + int'(out_vs == POL);
    end
    checks++; if (de_cnt != 0) begin failures++; $display("FAIL idle_de_count got=%0d exp=0", de_cnt); end
    checks++; if (fs_cnt != 0) begin failures++; $display("FAIL idle_fs_count got=%0d exp=0", fs_cnt); end
    checks++; if (rdy_cnt != 0) begin failures++; $display("FAIL idle_ready_count got=%0d exp=0", rdy_cnt); end
    checks++; if (hs_cnt != 0) begin failures++; $display("FAIL idle_sync_count got=%0d exp=0", hs_cnt); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drop_idx = 1;
    en = 1'b1;
    for (int k = 1; k <= 20; k++) tick();
    checks++; if (out_y !== 8'h0B) begin failures++; $display("FAIL pre_rst_y got=%h exp=0b", out_y); end
    checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL pre_rst_uf_err got=%b exp=1", underflow_err); end
    rst = 1'b1;
    tick();
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL mid_rst_y got=%h exp=00", out_y); end
    checks++; if (out_de !== 1'b0) begin failures++; $display("FAIL mid_rst_de got=%b exp=0", out_de); end
    checks++; if (out_hs !== ~POL || out_vs !== ~POL) begin failures++; $display("FAIL mid_rst_sync hs=%b vs=%b exp=%b", out_hs, out_vs, ~POL); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", pix_ready); end
    checks++; if (frame_start !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL mid_rst_pulses fs=%b uf=%b exp=0/0", frame_start, underflow); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL mid_rst_uf_err got=%b exp=0", underflow_err); end
    rst = 1'b0;
    idx = 0; drop_idx = -1; pix_data = 8'h01; pix_valid = 1'b1;
    tick();
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", pix_ready); end
    checks++; if (out_de !== 1'b0) begin failures++; $display("FAIL restart_de_early got=%b exp=0", out_de); end
    tick();
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL restart_fs got=%b exp=1", frame_start); end
    checks++; if (out_de !== 1'b1 || out_y !== 8'h01) begin failures++; $display("FAIL restart_pix de=%b y=%h exp=1/01", out_de, out_y); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_en_drop();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_stream_gen.md
# vid_stream_gen

Video stream source that produces the `y`/`de`/`hs`/`vs` pixel stream consumed by the filter chain (Gaussian, Sobel). It generates raster timing from parameterised h/v counters and pulls 8-bit pixels from an upstream FIFO with a valid/ready handshake. It reports FIFO underflow and is used both as the camera-to-pipeline bridge and as a bench stimulus source.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch
- `SYNC_POL`, 1, asserted level of `out_hs`/`out_vs` (1 = active-high)
- `clk`  in  1  pixel clock; one clock only
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  run request; sampled at frame boundaries only
- `pix_data`  in  8  upstream pixel
- `pix_valid`  in  1  `pix_data` valid
- `pix_ready`  out  1  pixel consumed this cycle when `pix_ready & pix_valid`
- `out_y`  out  8  pixel to filter chain
- `out_de`  out  1  active-video enable
- `out_hs`  out  1  horizontal sync
- `out_vs`  out  1  vertical sync
- `frame_start`  out  1  one-cycle pulse with the first active pixel of each frame
- `underflow`  out  1  one-cycle pulse per active pixel with no valid data
- `underflow_err`  out  1  sticky underflow flag; cleared only by `rst`

## Operation
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`; `V_TOTAL` is defined the same way. `h_cnt` counts 0..`H_TOTAL-1` and wraps; `v_cnt` increments on each `h_cnt` wrap and wraps at `V_TOTAL-1`.
- Region order per line and per frame: active, front porch, sync, back porch.
- `active = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE)`
- hsync region: `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`
- vsync region: the same rule on `v_cnt`, for the whole line.
- FSM states:
  - IDLE: counters held at 0, `pix_ready`=0, outputs at inactive level. IDLE→RUN when `en`=1.
  - RUN: counters advance every clock. At `h_cnt=H_TOTAL-1`, `v_cnt=V_TOTAL-1`: if `en`=0, go to IDLE (counters return to 0); otherwise wrap and continue. Dropping `en` mid-frame always completes the frame.
- `pix_ready = RUN & active`. This is combinational from registered state and never depends on `pix_valid`.
- On an active cycle with `pix_valid`=0, the block emits `out_y=8'h00`, pulses `underflow`, and sets `underflow_err`. Timing is never stalled; the raster continues.
- `pix_data` is never consumed outside active cycles, even when `pix_valid`=1.
- All counters are sized by `$clog2` of the totals; there is no arithmetic beyond increment/compare.

## Timing
- Latency is 1 clock. Counter state at cycle t drives `out_*`, `frame_start`, and `underflow` at t+1, all registered.
- `out_y` holds its last value when `out_de`=0.
- `frame_start` is asserted at t+1 for t with `h_cnt=0`, `v_cnt=0` in RUN.
- The first RUN cycle after IDLE has `h_cnt=v_cnt=0`; its pixel appears at `out_y` 2 clocks after `en` is sampled.
- Reset values:
  - `out_y`=0, `out_de`=0, `pix_ready`=0, `frame_start`=0, `underflow`=0, `underflow_err`=0.
  - `out_hs`=`out_vs`=`~SYNC_POL`.
  - FSM in IDLE, counters at 0.
- `rst` asserted mid-frame: in the next cycle all outputs are at reset values and the partial frame is abandoned. The upstream FIFO flush is the owner's responsibility.
- `en` and `rst` high together: `rst` wins.

## Structure
- Package `vid_timing_pkg` holds the FSM state enum (IDLE, RUN), default 640x480 timing constants, and `SYNC_POL` default.
- Sub-module `vid_timing_cnt` contains the h/v counters and region decode (`active`, `hs_reg`, `vs_reg`, `last_pix`). It has `run` and `clear` inputs. The top level holds the FSM, handshake, and output registers.

## Test plan
All scenarios use small timing: H 4/1/2/1 (`H_TOTAL` 8), V 3/1/1/1 (`V_TOTAL` 6), 48 clocks/frame.
- Reset, then `en`=1 with FIFO always valid carrying 0x01..0x0C → 12 `out_de` cycles; `out_y` reads 0x01..0x0C in order; `frame_start` pulses once, 2 clocks after `en`.
- Same run → `out_hs` asserted for 2 clocks per line starting 5 clocks after line start; `out_vs` asserted for 8 clocks on line 4; `pix_ready` count is 12 per frame.
- `pix_valid` dropped for the 3rd pixel only → `out_y`=0x00 at that position, one `underflow` pulse, `underflow_err`=1 sticky; remaining pixels are not shifted.
- `en` dropped at clock 10 of frame 1 → frame 1 completes all 48 clocks; IDLE follows; no further `frame_start`.
- `rst` pulsed at clock 20 with `en` held high → next cycle all outputs at reset values; after `rst` releases, a new frame starts with `h=v=0`.
- `pix_valid`=1 during blanking → `pix_ready`=0 and no data is consumed.
